// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the loader interface and the loader top.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [31:0] NOP_WORD       = 32'h00000013;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, memory write port and status bundle of the loader.
// slave = loader side, master = host/memory side.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int AW = 8
);

  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_written;
  logic          cpu_hold;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, done, error, words_written, cpu_hold
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, done, error, words_written, cpu_hold
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction memory
// as little-endian 32-bit words, holding the CPU in reset while loading.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int AW            = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);
  localparam logic [16:0] DEPTH_W   = 17'(DEPTH);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [15:0]   r_len;
  logic [1:0]    r_lane;
  logic [23:0]   r_shift;
  logic [7:0]    r_csum;
  logic [AW:0]   r_word_idx;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic          r_done;
  logic          r_error;
  logic          r_cpu_hold;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_start_ok;
  logic          w_word_end;
  logic          w_last_word;
  logic [15:0]   w_len_rx;
  logic [AW:0]   w_idx_inc;

  assign w_in_ready  = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                       (r_state == DATA)   || (r_state == CHK);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_start_ok  = bus.start &&
                       ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_len_rx    = {bus.in_data, r_len[7:0]};
  assign w_word_end  = (r_lane == LAST_LANE);
  assign w_idx_inc   = r_word_idx + (AW+1)'(1);
  assign w_last_word = (16'(w_idx_inc) == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: begin
        if (w_start_ok) w_next = LEN_LO;
      end
      LEN_LO: begin
        if (w_accept) w_next = LEN_HI;
      end
      LEN_HI: begin
        // Oversize frames are rejected before any write so the address never wraps.
        if (w_accept) begin
          if (w_len_rx == 16'd0) begin
            w_next = CHK;
          end else if ({1'b0, w_len_rx} > DEPTH_W) begin
            w_next = ERR;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA: begin
        if (w_accept && w_word_end && w_last_word) w_next = CHK;
      end
      CHK: begin
        if (w_accept) w_next = (bus.in_data == r_csum) ? DONE : ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_lane      <= '0;
      r_shift     <= '0;
      r_csum      <= '0;
      r_word_idx  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_hold  <= HOLD_AT_RESET;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= (w_next == DONE);
      r_error  <= (w_next == ERR);
      // IDLE is only reachable through reset, so it keeps the reset hold value.
      if (w_next == DONE) begin
        r_cpu_hold <= 1'b0;
      end else if (w_next != IDLE) begin
        r_cpu_hold <= 1'b1;
      end

      if (w_start_ok) begin
        r_len      <= '0;
        r_lane     <= '0;
        r_shift    <= '0;
        r_csum     <= '0;
        r_word_idx <= '0;
      end

      if (w_accept) begin
        unique case (r_state)
          LEN_LO: r_len[7:0]  <= bus.in_data;
          LEN_HI: r_len[15:8] <= bus.in_data;
          DATA: begin
            r_csum <= r_csum ^ bus.in_data;
            r_lane <= r_lane + 2'd1;
            if (w_word_end) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_idx[AW-1:0];
              r_mem_wdata <= {bus.in_data, r_shift};
              r_word_idx  <= w_idx_inc;
            end else begin
              r_shift <= {bus.in_data, r_shift[23:8]};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.busy          = w_in_ready;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.words_written = r_word_idx;
  assign bus.cpu_hold      = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed frame table, randomized frames with input gaps,
// and a mid-load reset, all checked against a frame-level reference model.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .HOLD_AT_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           nb;
    logic [127:0] bytes;
    bit           e_done;
    bit           e_err;
    int           e_words;
    bit           e_hold;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_pct  = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic          prev_we = 1'b0;

  logic [7:0]    frame[$];
  logic [31:0]   exp_words[$];
  bit            m_done;
  bit            m_error;
  int            m_accept;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      chk("mem_we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = bus.mem_we;
  end

  // Frame-level reference: length header, little-endian words, XOR over payload.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_words.delete();
    m_done  = 0;
    m_error = 0;
    n = int'({frame[1], frame[0]});
    if (n > DEPTH) begin
      m_error  = 1;
      m_accept = 2;
      return;
    end
    m_accept = 2 + 4 * n + 1;
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_words.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
      for (int k = 0; k < 4; k++) x ^= frame[2+4*w+k];
    end
    if (frame[2+4*n] == x) m_done = 1;
    else m_error = 1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input string tag);
    model();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    @(negedge clk);
    chk({tag, "_busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_hold_after_start"}, {31'd0, bus.cpu_hold}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < m_accept; i++) send_byte(frame[i]);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, m_done});
    chk({tag, "_error"}, {31'd0, bus.error}, {31'd0, m_error});
    chk({tag, "_words"}, 32'(bus.words_written), 32'(exp_words.size()));
    chk({tag, "_hold"}, {31'd0, bus.cpu_hold}, {31'd0, m_error});
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_words.size()));
    if (wr_addr_q.size() == exp_words.size()) begin
      for (int i = 0; i < exp_words.size(); i++) begin
        chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
        chk({tag, "_data"}, wr_data_q[i], exp_words[i]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    chk({tag, "_words"}, 32'(bus.words_written), 32'd0);
    chk({tag, "_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  task automatic build_random(input int n, input bit bad_chk);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] n16;
    frame.delete();
    n16 = 16'(n);
    frame.push_back(n16[7:0]);
    frame.push_back(n16[15:8]);
    x = 8'h00;
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        x ^= b;
      end
      frame.push_back(bad_chk ? (x ^ 8'(1 << $urandom_range(7))) : x);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{11, 128'h02_00_13_00_00_00_93_00_10_00_90_00_00_00_00_00, 1'b1, 1'b0, 2, 1'b0};
    vecs[1] = '{3,  128'h00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{2,  128'h01_01_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 1'b1};
    vecs[3] = '{11, 128'h02_00_13_00_00_00_93_00_10_00_91_00_00_00_00_00, 1'b0, 1'b1, 2, 1'b1};
    vecs[4] = '{7,  128'h01_00_AA_BB_CC_DD_00_00_00_00_00_00_00_00_00_00, 1'b1, 1'b0, 1, 1'b0};

    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst          = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("idle");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      frame.delete();
      for (int i = 0; i < vecs[v].nb; i++) frame.push_back(vecs[v].bytes[127-8*i -: 8]);
      run_frame(tag);
      chk({tag, "_tbl_done"}, {31'd0, bus.done}, {31'd0, vecs[v].e_done});
      chk({tag, "_tbl_error"}, {31'd0, bus.error}, {31'd0, vecs[v].e_err});
      chk({tag, "_tbl_words"}, 32'(bus.words_written), 32'(vecs[v].e_words));
      chk({tag, "_tbl_hold"}, {31'd0, bus.cpu_hold}, {31'd0, vecs[v].e_hold});
      check_model(tag);
      if (v == 0 && wr_data_q.size() == 2) begin
        chk("vec0_word0_nop", wr_data_q[0], NOP_WORD);
        chk("vec0_word1", wr_data_q[1], 32'h00100093);
      end
    end

    gap_pct = 40;
    build_random(DEPTH, 1'b0);
    run_frame("full256");
    check_model("full256");

    for (int r = 0; r < 6; r++) begin
      int n;
      n = (r == 5) ? $urandom_range(DEPTH + 1, DEPTH + 300) : $urandom_range(0, 12);
      build_random(n, 1'($urandom_range(1)));
      run_frame($sformatf("rand%0d", r));
      check_model($sformatf("rand%0d", r));
    end

    gap_pct = 0;
    build_random(8, 1'b0);
    model();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    for (int i = 0; i < 2 + 4 * 5 + 3; i++) send_byte(frame[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst_async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    chk("midrst_nwrites", 32'(wr_addr_q.size()), 32'd5);
    if (wr_data_q.size() == 5) chk("midrst_word4", wr_data_q[4], exp_words[4]);

    run_frame("after_rst");
    check_model("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
